jenc_bit_pack_stuff: RTL and testbench

Parametrised successor to the JPEG encoder's bit packer. It accepts variable-length, MSB-aligned Huffman code+coefficient words up to `IN_W` bits and packs them into a contiguous bitstream. When `STUFF=1` it performs JPEG byte stuffing, inserting 0x00 after every 0xFF byte. It emits `OUT_BYTES`-wide beats with a valid-byte count, sits between the Huffman/entropy coder and the JPEG header/output mux, and pads the final byte with 1s on `in_tlast`.

---
 rtl/jenc_pkg.sv | 15 +
 rtl/jenc_byte_stuffer.sv | 55 +++++
 rtl/jenc_bit_pack_stuff.sv | 116 +++++++++++
 tb/tb_jenc_bit_pack_stuff.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jenc_pkg.sv
// Shared constants and sizing helper for the JPEG entropy-coder bit packer.
// Covers marker and stuff byte values, the pad bit and the accumulator width.
package jenc_pkg;

  localparam logic [7:0] JPEG_FF    = 8'hFF;
  localparam logic [7:0] JPEG_STUFF = 8'h00;
  localparam logic       PAD_BIT    = 1'b1;

  // The accumulator must absorb one worst-case input word on top of a full beat,
  // plus one partial byte.
  function automatic int acc_width(input int in_w, input int out_bytes);
    return in_w + 8 * out_bytes + 8;
  endfunction

endpackage

// File: rtl/jenc_byte_stuffer.sv
// Combinational slot allocator: places complete accumulator bytes into beat slots.
// With STUFF set, every 0xFF byte is followed by 0x00, and a pair is never split.
module jenc_byte_stuffer
  import jenc_pkg::*;
#(
  parameter int OUT_BYTES = 4,
  parameter bit STUFF     = 1'b1
) (
  input  logic [8*OUT_BYTES-1:0]         top_bytes,
  input  logic [$clog2(OUT_BYTES+1)-1:0] avail,
  output logic [8*OUT_BYTES-1:0]         beat_data,
  output logic [$clog2(OUT_BYTES+1)-1:0] slots_used,
  output logic [$clog2(OUT_BYTES+1)-1:0] src_used,
  output logic                           blocked
);

  localparam int CNT_W = $clog2(OUT_BYTES + 1);

  int         slots;
  int         src;
  int         need;
  logic       stop;
  logic [7:0] byte_i;

  always_comb begin
    // NOTE: every variable gets a default before the loop; a path that leaves one
    // unassigned would infer a latch.
    beat_data = '0;
    slots     = 0;
    src       = 0;
    need      = 0;
    stop      = 1'b0;
    blocked   = 1'b0;
    byte_i    = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      byte_i = top_bytes[8*(OUT_BYTES-1-i) +: 8];
      need   = (STUFF && byte_i == JPEG_FF) ? 2 : 1;
      if (!stop && i < int'(avail)) begin
        if (slots + need <= OUT_BYTES) begin
          beat_data[8*(OUT_BYTES-1-slots) +: 8] = byte_i;
          if (need == 2) beat_data[8*(OUT_BYTES-2-slots) +: 8] = JPEG_STUFF;
          slots = slots + need;
          src   = src + 1;
        end else begin
          // A 0xFF/0x00 pair that does not fit closes the beat one slot short.
          stop    = 1'b1;
          blocked = 1'b1;
        end
      end
    end
    slots_used = CNT_W'(slots);
    src_used   = CNT_W'(src);
  end

endmodule

// File: rtl/jenc_bit_pack_stuff.sv
// Bit packer: appends MSB-aligned variable-length codes to an accumulator, drains
// complete bytes (optionally stuffed) into registered beats, pads and flushes on tlast.
module jenc_bit_pack_stuff
  import jenc_pkg::*;
#(
  parameter int IN_W      = 64,
  parameter int OUT_BYTES = 4,
  parameter bit STUFF     = 1'b1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [IN_W-1:0]                in_data,
  input  logic [$clog2(IN_W+1)-1:0]      in_nbits,
  input  logic                           in_tlast,
  input  logic                           in_valid,
  output logic                           in_hold,
  output logic [8*OUT_BYTES-1:0]         out_data,
  output logic [$clog2(OUT_BYTES+1)-1:0] out_nbytes,
  output logic                           out_tlast,
  output logic                           out_valid,
  input  logic                           out_hold
);

  localparam int ACC_W  = acc_width(IN_W, OUT_BYTES);
  localparam int FILL_W = $clog2(2 * ACC_W + 1);
  localparam int FB_W   = FILL_W - 3;
  localparam int CNT_W  = $clog2(OUT_BYTES + 1);
  localparam int BEAT_W = 8 * OUT_BYTES;

  logic [ACC_W-1:0]  acc, acc_drained, acc_next, word_ext, pad_mask;
  logic [FILL_W-1:0] fill, fill_base, new_fill, fill_next;
  logic [FB_W-1:0]   fill_bytes;
  logic [CNT_W-1:0]  avail, slots_used, src_used, taken;
  logic [BEAT_W-1:0] beat_data;
  logic [IN_W-1:0]   word_masked;
  logic [2:0]        pad_len;
  logic              flushing, blocked, out_free, tlast_busy;
  logic              all_fit, closed, beat_tlast, emit, accept;

  assign fill_bytes = fill[FILL_W-1:3];
  assign avail      = (fill_bytes > FB_W'(OUT_BYTES)) ? CNT_W'(OUT_BYTES) : CNT_W'(fill_bytes);

  jenc_byte_stuffer #(
    .OUT_BYTES (OUT_BYTES),
    .STUFF     (STUFF)
  ) u_stuffer (
    .top_bytes  (acc[ACC_W-1 -: BEAT_W]),
    .avail      (avail),
    .beat_data  (beat_data),
    .slots_used (slots_used),
    .src_used   (src_used),
    .blocked    (blocked)
  );

  // A beat closes when its slots are full or a stuffed pair spills to the next one;
  // while flushing, the tail goes out once every remaining byte fits.
  assign out_free   = ~(out_valid & out_hold);
  assign tlast_busy = out_valid & out_tlast;
  assign closed     = (slots_used == CNT_W'(OUT_BYTES)) | blocked;
  assign all_fit    = (fill_bytes <= FB_W'(OUT_BYTES)) && (FB_W'(src_used) == fill_bytes);
  assign beat_tlast = flushing & all_fit;
  assign emit       = out_free & ~tlast_busy & (closed | beat_tlast);
  assign taken      = emit ? src_used : '0;

  assign fill_base   = fill - FILL_W'({taken, 3'b000});
  assign acc_drained = acc << {taken, 3'b000};
  // Worst-case word width only, so in_hold never depends on in_valid or in_data.
  assign in_hold     = flushing | (fill_base + FILL_W'(IN_W) > FILL_W'(ACC_W));
  assign accept      = in_valid & ~in_hold;

  always_comb begin
    word_masked = in_data & ~({IN_W{1'b1}} >> in_nbits);
    word_ext    = {word_masked, {(ACC_W-IN_W){1'b0}}} >> fill_base;
    new_fill    = fill_base + FILL_W'(in_nbits);
    pad_len     = 3'd0 - new_fill[2:0];
    pad_mask    = ({ACC_W{1'b1}} >> new_fill) & ~({ACC_W{1'b1}} >> (new_fill + FILL_W'(pad_len)));
    acc_next    = acc_drained;
    fill_next   = fill_base;
    if (accept) begin
      acc_next  = acc_drained | word_ext;
      fill_next = new_fill;
      if (in_tlast) begin
        acc_next  = acc_next | ({ACC_W{PAD_BIT}} & pad_mask);
        fill_next = new_fill + FILL_W'(pad_len);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge here, so resetn only acts while clk runs.
    if (!resetn) begin
      acc        <= '0;
      fill       <= '0;
      flushing   <= 1'b0;
      out_valid  <= 1'b0;
      out_tlast  <= 1'b0;
      out_nbytes <= '0;
      out_data   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      acc  <= acc_next;
      fill <= fill_next;
      if (tlast_busy && !out_hold) flushing <= 1'b0;
      else if (accept && in_tlast) flushing <= 1'b1;
      if (out_free) begin
        out_valid <= emit;
        if (emit) begin
          out_data   <= beat_data;
          out_nbytes <= slots_used;
          out_tlast  <= beat_tlast;
        end
      end
    end
  end

endmodule

// File: tb/tb_jenc_bit_pack_stuff.sv
// Directed bench for jenc_bit_pack_stuff (IN_W=64, OUT_BYTES=4, STUFF=1):
// packing, stuffing, padding, boundary flush, backpressure and mid-flush reset.
module tb_jenc_bit_pack_stuff;

  localparam int IN_W = 64;
  localparam int OB   = 4;

  typedef struct {
    logic [8*OB-1:0] data;
    logic [2:0]      nbytes;
    logic            tlast;
  } beat_t;

  logic            clk;
  logic            resetn;
  logic [IN_W-1:0] in_data;
  logic [6:0]      in_nbits;
  logic            in_tlast;
  logic            in_valid;
  logic            in_hold;
  logic [8*OB-1:0] out_data;
  logic [2:0]      out_nbytes;
  logic            out_tlast;
  logic            out_valid;
  logic            out_hold;

  int    total;
  int    bad;
  int    hold_mode;
  beat_t beats[$];
  bit    gold_bits[$];
  logic [7:0] gold_bytes[$];
  logic [7:0] got_bytes[$];

  jenc_bit_pack_stuff #(
    .IN_W      (IN_W),
    .OUT_BYTES (OB),
    .STUFF     (1'b1)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_data    (in_data),
    .in_nbits   (in_nbits),
    .in_tlast   (in_tlast),
    .in_valid   (in_valid),
    .in_hold    (in_hold),
    .out_data   (out_data),
    .out_nbytes (out_nbytes),
    .out_tlast  (out_tlast),
    .out_valid  (out_valid),
    .out_hold   (out_hold)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream stall: 0 = never, 1 = random, 2 = always.
  initial begin
    out_hold = 1'b0;
    forever begin
      @(negedge clk);
      out_hold = (hold_mode == 2) ? 1'b1 : (hold_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Beat monitor: records accepted beats and checks held beats stay put.
  initial begin
    beat_t prev;
    bit    prev_held;
    prev_held = 1'b0;
    prev      = '{default: '0};
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        prev_held = 1'b0;
      end else begin
        if (prev_held) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_data", 64'(out_data), 64'(prev.data));
          check("hold_nbytes", 64'(out_nbytes), 64'(prev.nbytes));
          check("hold_tlast", 64'(out_tlast), 64'(prev.tlast));
        end
        if (out_valid && !out_hold) beats.push_back('{out_data, out_nbytes, out_tlast});
        prev_held = out_valid && out_hold;
        prev      = '{out_data, out_nbytes, out_tlast};
      end
    end
  end

  task automatic send_word(input logic [IN_W-1:0] d, input int nbits, input logic last);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_nbits = 7'(nbits);
    in_tlast = last;
    #1;
    cyc = 0;
    while (in_hold && cyc < 3000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 3000) begin
      check("send_word_timeout", 64'(in_hold), 64'd0);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_beats(input int n, input string tag);
    int cyc;
    cyc = 0;
    while (beats.size() < n && cyc < 3000) begin
      @(negedge clk);
      #3;
      cyc++;
    end
    if (beats.size() < n) check({tag, "_timeout"}, 64'(beats.size()), 64'(n));
  endtask

  function automatic beat_t get_beat(input int idx);
    if (idx < beats.size()) return beats[idx];
    return '{data: 'x, nbytes: 'x, tlast: 1'bx};
  endfunction

  task automatic check_beat(input string tag, input int idx, input logic [31:0] d,
                            input logic [2:0] nb, input logic tl);
    beat_t b;
    b = get_beat(idx);
    check({tag, "_data"}, 64'(b.data), 64'(d));
    check({tag, "_nbytes"}, 64'(b.nbytes), 64'(nb));
    check({tag, "_tlast"}, 64'(b.tlast), 64'(tl));
  endtask

  initial begin
    int base;
    logic [31:0] exp1 [4];
    total     = 0;
    bad       = 0;
    hold_mode = 0;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_nbits  = '0;
    in_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_tlast", 64'(out_tlast), 64'd0);
    check("rst_out_nbytes", 64'(out_nbytes), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_in_hold", 64'(in_hold), 64'd0);

    // 16 single-byte words 0x12..0x21, last with tlast.
    exp1 = '{32'h12131415, 32'h16171819, 32'h1A1B1C1D, 32'h1E1F2021};
    base = beats.size();
    for (int i = 0; i < 16; i++) send_word({8'(8'h12 + i), 56'h0}, 8, i == 15);
    wait_beats(base + 4, "pack16");
    for (int i = 0; i < 4; i++) check_beat($sformatf("pack16_b%0d", i), base + i, exp1[i], 3'd4, i == 3);

    // 24 bits of 0xFF with tlast: stuffed pairs never split.
    base = beats.size();
    send_word({24'hFFFFFF, 40'h0}, 24, 1'b1);
    wait_beats(base + 2, "stuff3");
    check_beat("stuff3_b0", base, 32'hFF00FF00, 3'd4, 1'b0);
    check_beat("stuff3_b1", base + 1, 32'hFF000000, 3'd2, 1'b1);

    // Five-bit words padded with 1s.
    base = beats.size();
    send_word({5'b10101, 59'h0}, 5, 1'b1);
    wait_beats(base + 1, "pad_af");
    check_beat("pad_af", base, 32'hAF000000, 3'd1, 1'b1);
    base = beats.size();
    send_word({5'b11111, 59'h0}, 5, 1'b1);
    wait_beats(base + 1, "pad_ff");
    check_beat("pad_ff", base, 32'hFF000000, 3'd2, 1'b1);

    // Stream ending exactly on a beat boundary.
    base = beats.size();
    send_word(64'h0, 32, 1'b0);
    send_word(64'hDEAD_BEEF_0000_0000, 0, 1'b1);
    wait_beats(base + 2, "boundary");
    check_beat("boundary_b0", base, 32'h00000000, 3'd4, 1'b0);
    check_beat("boundary_b1", base + 1, 32'h00000000, 3'd0, 1'b1);

    // 1000 random words under random backpressure against a golden stuffed stream.
    begin
      logic [IN_W-1:0] d;
      int nb, mism, first_bad, tl_cnt, short_cnt, cyc;
      base = beats.size();
      gold_bits.delete();
      hold_mode = 1;
      for (int w = 0; w < 1000; w++) begin
        nb = $urandom_range(0, IN_W);
        for (int k = 0; k < 8; k++)
          d[8*k +: 8] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
        for (int k = 0; k < nb; k++) gold_bits.push_back(d[IN_W-1-k]);
        send_word(d, nb, w == 999);
      end
      while (gold_bits.size() % 8 != 0) gold_bits.push_back(1'b1);
      gold_bytes.delete();
      for (int k = 0; k < gold_bits.size(); k += 8) begin
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[7-j] = gold_bits[k+j];
        gold_bytes.push_back(b);
        if (b == 8'hFF) gold_bytes.push_back(8'h00);
      end
      cyc = 0;
      while (!(beats.size() > base && beats[beats.size()-1].tlast) && cyc < 20000) begin
        @(negedge clk);
        #3;
        cyc++;
      end
      hold_mode = 0;
      check("rand_end_seen", 64'(cyc < 20000), 64'd1);
      got_bytes.delete();
      tl_cnt    = 0;
      short_cnt = 0;
      for (int i = base; i < beats.size(); i++) begin
        for (int j = 0; j < int'(beats[i].nbytes); j++) got_bytes.push_back(beats[i].data[8*(OB-1-j) +: 8]);
        if (beats[i].tlast) tl_cnt++;
        else if (int'(beats[i].nbytes) < OB - 1) short_cnt++;
      end
      check("rand_len", 64'(got_bytes.size()), 64'(gold_bytes.size()));
      mism      = 0;
      first_bad = -1;
      for (int i = 0; i < gold_bytes.size() && i < got_bytes.size(); i++)
        if (got_bytes[i] !== gold_bytes[i]) begin
          mism++;
          if (first_bad < 0) first_bad = i;
        end
      check("rand_byte_mismatches", 64'(mism), 64'd0);
      check("rand_tlast_count", 64'(tl_cnt), 64'd1);
      check("rand_short_beats", 64'(short_cnt), 64'd0);
    end

    // Reset while a tlast beat with 20 packed bits is held downstream.
    hold_mode = 2;
    @(negedge clk);
    send_word({20'hABCDE, 44'h0}, 20, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("midflush_held_valid", 64'(out_valid), 64'd1);
    check("midflush_held_data", 64'(out_data), 64'hABCDEF00);
    check("midflush_in_hold", 64'(in_hold), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("midflush_rst_valid", 64'(out_valid), 64'd0);
    check("midflush_rst_in_hold", 64'(in_hold), 64'd0);
    check("midflush_rst_data", 64'(out_data), 64'd0);
    check("midflush_rst_nbytes", 64'(out_nbytes), 64'd0);
    hold_mode = 0;
    base = beats.size();
    send_word({8'h5A, 56'h0}, 8, 1'b1);
    wait_beats(base + 1, "after_rst");
    repeat (4) @(negedge clk);
    check_beat("after_rst", base, 32'h5A000000, 3'd1, 1'b1);
    check("after_rst_count", 64'(beats.size() - base), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
